// File: rtl/layer_frame_relay.sv
// Single-frame relay: capture LEN words from upstream (optional ReLU on write), then replay them in order downstream.
// Latency: word 0 is presented the cycle after the last upstream accept; outputs are decoded from registered state only, so neither valid nor ready depends combinationally on the other side.
module layer_frame_relay #(
  parameter int WIDTH  = 16,
  parameter int LEN    = 32,
  parameter int LOGLEN = 6,
  parameter int RELU   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_y,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  output logic signed [WIDTH-1:0] m_data_out_x,
  output logic                    m_valid_x,
  input  logic                    m_ready_x,
  output logic                    frame_done
);

  localparam int AW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [LOGLEN-1:0] LAST = LOGLEN'(LEN - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [LOGLEN-1:0] wp, wp_nxt;
  logic [LOGLEN-1:0] rp, rp_nxt;
  logic              done_nxt;
  logic              wr_en;
  logic signed [WIDTH-1:0] wr_dat;
  logic signed [WIDTH-1:0] mem [LEN];

  // Clamp happens once at write so the replay path is a plain register read.
  assign wr_dat = ((RELU != 0) && s_data_in_y[WIDTH-1]) ? '0 : s_data_in_y;

  always_comb begin
    state_nxt = state;
    wp_nxt    = wp;
    rp_nxt    = rp;
    done_nxt  = 1'b0;
    wr_en     = 1'b0;
    s_ready_y = (state == FILL);
    m_valid_x = (state == DRAIN);
    case (state)
      FILL: begin
        if (s_valid_y) begin
          wr_en = 1'b1;
          if (wp == LAST) begin
            wp_nxt    = '0;
            rp_nxt    = '0;
            state_nxt = DRAIN;
          end else begin
            wp_nxt = wp + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (m_ready_x) begin
          if (rp == LAST) begin
            rp_nxt    = '0;
            done_nxt  = 1'b1;
            state_nxt = FILL;
          end else begin
            rp_nxt = rp + 1'b1;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      wp         <= '0;
      rp         <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      wp         <= wp_nxt;
      rp         <= rp_nxt;
      frame_done <= done_nxt;
    end
  end

  // Buffer contents are don't-care after reset; the output mux hides them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp[AW-1:0]] <= wr_dat;
  end

  assign m_data_out_x = (state == DRAIN) ? mem[rp[AW-1:0]] : '0;

endmodule

// File: tb/tb_layer_frame_relay.sv
// Directed bench for layer_frame_relay: a RELU=0 and a RELU=1 instance share all inputs.
// Inputs change on the falling edge; outputs are sampled there too, before the next rising edge.
module tb_layer_frame_relay;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [15:0] s_data_in_y = '0;
  logic s_valid_y = 1'b0;
  logic m_ready_x = 1'b0;

  logic raw_s_ready, raw_m_valid, raw_done;
  logic signed [15:0] raw_dat;
  logic relu_s_ready, relu_m_valid, relu_done;
  logic signed [15:0] relu_dat;

  always #5 clk = ~clk;

  layer_frame_relay #(.WIDTH(16), .LEN(32), .LOGLEN(6), .RELU(0)) u_raw (
    .clk(clk), .reset(reset),
    .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y), .s_ready_y(raw_s_ready),
    .m_data_out_x(raw_dat), .m_valid_x(raw_m_valid), .m_ready_x(m_ready_x),
    .frame_done(raw_done)
  );

  layer_frame_relay #(.WIDTH(16), .LEN(32), .LOGLEN(6), .RELU(1)) u_relu (
    .clk(clk), .reset(reset),
    .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y), .s_ready_y(relu_s_ready),
    .m_data_out_x(relu_dat), .m_valid_x(relu_m_valid), .m_ready_x(m_ready_x),
    .frame_done(relu_done)
  );

  int checks = 0;
  int errors = 0;

  logic signed [15:0] din_q[$];
  logic signed [15:0] raw_q[$];
  logic signed [15:0] relu_q[$];
  int cyc, first_vld_cyc, last_in_cyc, done_cnt, done_cyc, b_first_cyc;
  int stab_err, extra_in, overlap;
  bit timeout;

  // Stimulus engine only: drives one or more frames and records what the downstream side accepted.
  task automatic run(input int n_out, input bit rdy_rand, input bit vld_toggle, input bit hold_vld);
    int idx = 0;
    bit prev_stall = 0;
    logic signed [15:0] prev_dat = '0;
    raw_q.delete(); relu_q.delete();
    cyc = 0; first_vld_cyc = -1; last_in_cyc = -1; done_cnt = 0; done_cyc = -1;
    b_first_cyc = -1; stab_err = 0; extra_in = 0; overlap = 0; timeout = 0;
    while (raw_q.size() < n_out) begin
      @(negedge clk);
      if (cyc > 3000) begin
        timeout = 1;
        break;
      end
      if (raw_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (raw_m_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (raw_m_valid && raw_s_ready) overlap++;
      if (prev_stall && (!raw_m_valid || raw_dat !== prev_dat)) stab_err++;
      if (idx < din_q.size()) begin
        s_valid_y   = vld_toggle ? (cyc % 2 == 1) : 1'b1;
        s_data_in_y = din_q[idx];
      end else begin
        s_valid_y   = hold_vld;
        s_data_in_y = 16'sh7777;
      end
      m_ready_x = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (s_valid_y && raw_s_ready) begin
        if (idx < din_q.size()) begin
          if (idx == 32) b_first_cyc = cyc;
          idx++;
          if (idx == 32) last_in_cyc = cyc;
        end else begin
          extra_in++;
        end
      end
      if (m_ready_x && raw_m_valid) begin
        raw_q.push_back(raw_dat);
        relu_q.push_back(relu_dat);
      end
      prev_stall = raw_m_valid && !m_ready_x;
      prev_dat   = raw_dat;
      cyc++;
    end
    @(negedge clk);
    if (raw_done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    s_valid_y = 1'b0;
    m_ready_x = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (raw_s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", raw_s_ready); end
    checks++; if (raw_m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", raw_m_valid); end
    checks++; if (raw_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", raw_done); end
    checks++; if (raw_dat !== 16'sd0) begin errors++; $display("FAIL reset_data got %0d want 0", raw_dat); end
    checks++; if (relu_m_valid !== 1'b0) begin errors++; $display("FAIL reset_relu_m_valid got %b want 0", relu_m_valid); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (raw_s_ready !== 1'b1 || raw_m_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got rdy=%b vld=%b want rdy=1 vld=0", raw_s_ready, raw_m_valid);
    end
  endtask

  task automatic test_basic;
    din_q.delete();
    for (int i = 0; i < 32; i++) din_q.push_back(16'(i));
    run(32, 0, 0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL basic_timeout got 1 want 0"); end
    for (int i = 0; i < 32; i++) begin
      checks++; if (raw_q[i] !== 16'(i)) begin errors++; $display("FAIL basic_word%0d got %0d want %0d", i, raw_q[i], i); end
    end
    checks++; if (last_in_cyc !== 31) begin errors++; $display("FAIL basic_last_in got %0d want 31", last_in_cyc); end
    checks++; if (first_vld_cyc !== 32) begin errors++; $display("FAIL basic_first_valid got %0d want 32", first_vld_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    checks++; if (done_cyc !== 64) begin errors++; $display("FAIL basic_done_cycle got %0d want 64", done_cyc); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL basic_overlap got %0d want 0", overlap); end
  endtask

  task automatic test_relu;
    logic signed [15:0] inp [6];
    logic signed [15:0] exp_relu [6];
    inp      = '{-16'sd164, -16'sd2, 16'sd152, 16'sd0, -16'sd32768, 16'sd223};
    exp_relu = '{16'sd0, 16'sd0, 16'sd152, 16'sd0, 16'sd0, 16'sd223};
    din_q.delete();
    for (int i = 0; i < 6; i++) din_q.push_back(inp[i]);
    for (int i = 0; i < 26; i++) din_q.push_back(16'sd5);
    run(32, 0, 0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL relu_timeout got 1 want 0"); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (relu_q[i] !== exp_relu[i]) begin errors++; $display("FAIL relu_word%0d got %0d want %0d", i, relu_q[i], exp_relu[i]); end
      checks++; if (raw_q[i] !== inp[i]) begin errors++; $display("FAIL raw_word%0d got %0d want %0d", i, raw_q[i], inp[i]); end
    end
    for (int i = 6; i < 32; i++) begin
      checks++; if (relu_q[i] !== 16'sd5) begin errors++; $display("FAIL relu_word%0d got %0d want 5", i, relu_q[i]); end
    end
  endtask

  task automatic test_backpressure;
    din_q.delete();
    for (int i = 0; i < 32; i++) din_q.push_back(16'(1000 + 7 * i));
    run(32, 1, 0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL bp_timeout got 1 want 0"); end
    checks++; if (raw_q.size() !== 32) begin errors++; $display("FAIL bp_accepts got %0d want 32", raw_q.size()); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles want 0", stab_err); end
    for (int i = 0; i < 32; i++) begin
      checks++; if (raw_q[i] !== 16'(1000 + 7 * i)) begin errors++; $display("FAIL bp_word%0d got %0d want %0d", i, raw_q[i], 1000 + 7 * i); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_gaps;
    din_q.delete();
    for (int i = 0; i < 32; i++) din_q.push_back(16'(-50 + 3 * i));
    run(32, 0, 1, 1);
    checks++; if (timeout) begin errors++; $display("FAIL gap_timeout got 1 want 0"); end
    checks++; if (last_in_cyc !== 63) begin errors++; $display("FAIL gap_last_in got %0d want 63", last_in_cyc); end
    checks++; if (first_vld_cyc !== 64) begin errors++; $display("FAIL gap_first_valid got %0d want 64", first_vld_cyc); end
    checks++; if (extra_in !== 0) begin errors++; $display("FAIL gap_extra_accepts got %0d want 0", extra_in); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL gap_ready_in_drain got %0d want 0", overlap); end
    for (int i = 0; i < 32; i++) begin
      checks++; if (raw_q[i] !== 16'(-50 + 3 * i)) begin errors++; $display("FAIL gap_word%0d got %0d want %0d", i, raw_q[i], -50 + 3 * i); end
    end
  endtask

  task automatic test_back_to_back;
    din_q.delete();
    for (int i = 0; i < 32; i++) din_q.push_back(16'(100 + i));
    for (int i = 0; i < 32; i++) din_q.push_back(16'(200 + i));
    run(64, 0, 0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL b2b_timeout got 1 want 0"); end
    for (int i = 0; i < 64; i++) begin
      checks++; if (raw_q[i] !== 16'((i < 32) ? 100 + i : 200 + i - 32)) begin
        errors++; $display("FAIL b2b_word%0d got %0d want %0d", i, raw_q[i], (i < 32) ? 100 + i : 200 + i - 32);
      end
    end
    checks++; if (done_cyc !== 64) begin errors++; $display("FAIL b2b_done_a got %0d want 64", done_cyc); end
    checks++; if (b_first_cyc !== 64) begin errors++; $display("FAIL b2b_first_b got %0d want 64", b_first_cyc); end
    checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
  endtask

  task automatic test_reset_mid;
    din_q.delete();
    for (int i = 0; i < 32; i++) din_q.push_back(16'(50 + i));
    run(10, 0, 0, 0);
    reset = 1'b0;
    #1;
    checks++; if (raw_m_valid !== 1'b0 || raw_s_ready !== 1'b1 || raw_done !== 1'b0) begin
      errors++; $display("FAIL midrst_during got vld=%b rdy=%b done=%b want 0 1 0", raw_m_valid, raw_s_ready, raw_done);
    end
    checks++; if (raw_dat !== 16'sd0) begin errors++; $display("FAIL midrst_data got %0d want 0", raw_dat); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (raw_m_valid !== 1'b0 || raw_s_ready !== 1'b1 || raw_done !== 1'b0) begin
      errors++; $display("FAIL midrst_after got vld=%b rdy=%b done=%b want 0 1 0", raw_m_valid, raw_s_ready, raw_done);
    end
    din_q.delete();
    for (int i = 0; i < 32; i++) din_q.push_back(16'(300 + i));
    run(32, 0, 0, 0);
    checks++; if (timeout) begin errors++; $display("FAIL midrst_timeout got 1 want 0"); end
    for (int i = 0; i < 32; i++) begin
      checks++; if (raw_q[i] !== 16'(300 + i)) begin errors++; $display("FAIL midrst_word%0d got %0d want %0d", i, raw_q[i], 300 + i); end
    end
    checks++; if (first_vld_cyc !== 32) begin errors++; $display("FAIL midrst_first_valid got %0d want 32", first_vld_cyc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_backpressure();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
